// File: rtl/mult_load_sequencer.sv
// Sequencer for the parallel multiplier datapath: accepts an operand pair, pulses the
// loader, waits out the multiplier latency, then holds the captured lane products for downstream.
module mult_load_sequencer #(
  parameter int MULT_LAT = 2,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        abort,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_nums_a,
  input  logic [31:0] in_nums_b,
  output logic [31:0] nums_a,
  output logic [31:0] nums_b,
  output logic        load,
  input  logic [63:0] prod_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        busy,
  output logic [15:0] op_count
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_DONE} state_t;

  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_load, r_out_valid;
  logic [31:0]        r_nums_a, r_nums_b;
  logic [63:0]        r_out_data;
  logic [15:0]        r_op_count;
  logic               w_accept, w_cap, w_ret;

  assign in_ready  = (r_state == S_IDLE) && !abort;
  assign busy      = (r_state != S_IDLE);
  assign w_accept  = in_valid && in_ready;
  assign w_cap     = (r_state == S_WAIT) && (r_cnt == '0);
  assign w_ret     = (r_state == S_DONE) && out_ready;

  assign nums_a    = r_nums_a;
  assign nums_b    = r_nums_b;
  assign load      = r_load;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign op_count  = r_op_count;

  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_accept) w_next = S_LOAD;
        S_LOAD:  w_next = S_WAIT;
        S_WAIT:  if (w_cap) w_next = S_DONE;
        S_DONE:  if (w_ret) w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Abort clears only the control state; captured data and operands stay visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_load      <= 1'b0;
      r_nums_a    <= '0;
      r_nums_b    <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_op_count  <= '0;
    end else if (abort) begin
      r_cnt       <= '0;
      r_load      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_load <= w_accept;
      if (w_accept) begin
        r_nums_a <= in_nums_a;
        r_nums_b <= in_nums_b;
      end
      if (r_state == S_LOAD)
        r_cnt <= CNT_W'(MULT_LAT - 1);
      else if (r_state == S_WAIT && r_cnt != '0)
        r_cnt <= r_cnt - 1'b1;
      if (w_cap) begin
        r_out_data  <= prod_in;
        r_out_valid <= 1'b1;
      end else if (w_ret) begin
        r_out_valid <= 1'b0;
        r_op_count  <= r_op_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mult_load_sequencer.sv
// Directed bench for mult_load_sequencer at latencies 2, 1 and 15, with a product scoreboard.
module tb_mult_load_sequencer;

  localparam logic [63:0] GARB = 64'hDEAD_BEEF_0BAD_F00D;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] in_nums_a = '0, in_nums_b = '0;
  logic [63:0] prod_in = GARB;

  logic        in_valid [3];
  logic        out_ready[3];
  logic        in_ready [3];
  logic        busy     [3];
  logic        load     [3];
  logic        out_valid[3];
  logic [31:0] nums_a   [3];
  logic [31:0] nums_b   [3];
  logic [63:0] out_data [3];
  logic [15:0] op_count [3];

  int          lat_tab[3] = '{2, 1, 15};
  logic [15:0] exp_cnt[3];
  logic [63:0] sb_q[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mult_load_sequencer #(.MULT_LAT(2), .CNT_W(4)) u_l2 (
    .clk(clk), .rst_n(rst_n), .abort(abort), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_nums_a(in_nums_a), .in_nums_b(in_nums_b), .nums_a(nums_a[0]), .nums_b(nums_b[0]),
    .load(load[0]), .prod_in(prod_in), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .busy(busy[0]), .op_count(op_count[0]));

  mult_load_sequencer #(.MULT_LAT(1), .CNT_W(4)) u_l1 (
    .clk(clk), .rst_n(rst_n), .abort(abort), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_nums_a(in_nums_a), .in_nums_b(in_nums_b), .nums_a(nums_a[1]), .nums_b(nums_b[1]),
    .load(load[1]), .prod_in(prod_in), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .busy(busy[1]), .op_count(op_count[1]));

  mult_load_sequencer #(.MULT_LAT(15), .CNT_W(4)) u_l15 (
    .clk(clk), .rst_n(rst_n), .abort(abort), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_nums_a(in_nums_a), .in_nums_b(in_nums_b), .nums_a(nums_a[2]), .nums_b(nums_b[2]),
    .load(load[2]), .prod_in(prod_in), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_data(out_data[2]), .busy(busy[2]), .op_count(op_count[2]));

  function automatic logic [63:0] lmul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    for (int i = 0; i < 4; i++)
      p[63-16*i -: 16] = 16'(a[31-8*i -: 8]) * 16'(b[31-8*i -: 8]);
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives prod_in with the true product only in the single cycle before the capture edge.
  task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b, input int hold);
    int          lat = lat_tab[k];
    int          n = 0;
    logic [63:0] exp = GARB;
    while (!in_ready[k] && n < 20) begin step(); n++; end
    chk("accept_ready", 64'(in_ready[k]), 64'd1);
    in_valid[k] = 1'b1; in_nums_a = a; in_nums_b = b;
    sb_q.push_back(lmul(a, b));
    step();
    in_valid[k] = 1'b0; in_nums_a = $urandom; in_nums_b = $urandom; prod_in = GARB;
    chk("load_hi", 64'(load[k]), 64'd1);
    chk("nums_a", 64'(nums_a[k]), 64'(a));
    chk("nums_b", 64'(nums_b[k]), 64'(b));
    chk("busy", 64'(busy[k]), 64'd1);
    step();
    chk("load_lo", 64'(load[k]), 64'd0);
    chk("nums_a_hold", 64'(nums_a[k]), 64'(a));
    for (int i = 1; i < lat; i++) begin
      chk("early_valid", 64'(out_valid[k]), 64'd0);
      step();
    end
    chk("early_valid", 64'(out_valid[k]), 64'd0);
    prod_in = lmul(a, b);
    step();
    prod_in = GARB;
    chk("valid_rise", 64'(out_valid[k]), 64'd1);
    if (sb_q.size() > 0) exp = sb_q.pop_front();
    chk("out_data", out_data[k], exp);
    repeat (hold) begin
      step();
      chk("bp_valid", 64'(out_valid[k]), 64'd1);
      chk("bp_data", out_data[k], exp);
      chk("bp_in_ready", 64'(in_ready[k]), 64'd0);
    end
    out_ready[k] = 1'b1;
    step();
    out_ready[k] = 1'b0;
    exp_cnt[k] = exp_cnt[k] + 16'd1;
    chk("op_count", 64'(op_count[k]), 64'(exp_cnt[k]));
    chk("valid_drop", 64'(out_valid[k]), 64'd0);
    chk("idle_ready", 64'(in_ready[k]), 64'd1);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0; out_ready[k] = 1'b0; exp_cnt[k] = '0;
    end
    step(); step();
    rst_n = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      chk("rst_in_ready", 64'(in_ready[k]), 64'd1);
      chk("rst_busy", 64'(busy[k]), 64'd0);
      chk("rst_load", 64'(load[k]), 64'd0);
      chk("rst_valid", 64'(out_valid[k]), 64'd0);
      chk("rst_data", out_data[k], 64'd0);
      chk("rst_count", 64'(op_count[k]), 64'd0);
    end

    run_op(0, 32'h01020304, 32'h05060708, 0);
    chk("single_data", out_data[0], 64'h0005000C00150020);
    run_op(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 10);
    chk("bp_const", out_data[0], 64'hFE01FE01FE01FE01);

    // abort in IDLE blocks acceptance
    abort = 1'b1; in_valid[0] = 1'b1; in_nums_a = 32'h0; #1;
    chk("abort_idle_ready", 64'(in_ready[0]), 64'd0);
    step();
    abort = 1'b0; in_valid[0] = 1'b0;
    chk("abort_idle_busy", 64'(busy[0]), 64'd0);
    chk("abort_idle_nums", 64'(nums_a[0]), 64'hFFFFFFFF);

    // abort in the first WAIT cycle
    in_valid[0] = 1'b1; in_nums_a = 32'h11111111; in_nums_b = 32'h22222222;
    step(); in_valid[0] = 1'b0;
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", 64'(busy[0]), 64'd0);
    chk("abort_load", 64'(load[0]), 64'd0);
    chk("abort_nums", 64'(nums_a[0]), 64'h11111111);
    repeat (4) begin
      prod_in = GARB;
      step();
      chk("abort_no_valid", 64'(out_valid[0]), 64'd0);
    end
    chk("abort_count", 64'(op_count[0]), 64'(exp_cnt[0]));
    run_op(0, 32'h0A0B0C0D, 32'h10203040, 2);

    // asynchronous reset while in WAIT
    in_valid[0] = 1'b1; in_nums_a = 32'h11223344; in_nums_b = 32'h55667788;
    step(); in_valid[0] = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_load", 64'(load[0]), 64'd0);
    chk("arst_nums_a", 64'(nums_a[0]), 64'd0);
    chk("arst_nums_b", 64'(nums_b[0]), 64'd0);
    chk("arst_data", out_data[0], 64'd0);
    chk("arst_valid", 64'(out_valid[0]), 64'd0);
    chk("arst_count", 64'(op_count[0]), 64'd0);
    chk("arst_busy", 64'(busy[0]), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    for (int k = 0; k < 3; k++) exp_cnt[k] = '0;
    chk("post_rst_ready", 64'(in_ready[0]), 64'd1);
    chk("post_rst_busy", 64'(busy[0]), 64'd0);
    chk("post_rst_count", 64'(op_count[0]), 64'd0);

    run_op(1, 32'h12345678, 32'h9ABCDEF0, 0);
    run_op(2, 32'h80FF7F01, 32'h02FF8001, 1);
    run_op(2, 32'h00FF0102, 32'hFF00FE03, 0);

    // wrap: preload the counter, then one more op
    force u_l1.r_op_count = 16'hFFFF;
    step();
    release u_l1.r_op_count;
    exp_cnt[1] = 16'hFFFF;
    run_op(1, 32'h03030303, 32'h04040404, 0);
    chk("wrap_zero", 64'(op_count[1]), 64'd0);

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
